hcsr04_emulador: RTL

Behavioural-synthesizable emulator of the HC-SR04 ultrasonic sensor: the responder end of the trigger/echo protocol. It accepts the trigger pulse produced by our interface unit, waits the ultrasonic burst time, then drives an echo pulse whose width encodes a programmed distance. It sits on the FPGA in place of the physical sensor, for board bring-up and closed-loop simulation of the measurement chain.

---
 rtl/hcsr04_emu_pkg.sv | 28 ++
 rtl/hcsr04_gerador_echo.sv | 61 ++++++
 rtl/hcsr04_emulador.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hcsr04_emu_pkg.sv
// Shared state encodings and default timing for the HC-SR04 emulator.
// The HCSR04_EMU_DEBUG_EN macro enables the debug outputs.
package hcsr04_emu_pkg;

   typedef enum logic [2:0] {
      REPOUSO      = 3'd0,
      MEDE_TRIGGER = 3'd1,
      RAJADA       = 3'd2,
      ECHO_ALTO    = 3'd3,
      RECUPERACAO  = 3'd4
   } estado_t;

   localparam logic [3:0] DB_ILEGAL = 4'hE;
   localparam int DIST_W = 9;

   localparam int DEF_CLK_HZ          = 50_000_000;
   localparam int DEF_TRIG_MIN_CYCLES = 500;
   localparam int DEF_BURST_CYCLES    = 10_000;
   localparam int DEF_CYCLES_PER_CM   = 2941;
   localparam int DEF_MAX_CM          = 400;
   localparam int DEF_TIMEOUT_CYCLES  = 1_900_000;
   localparam int DEF_RECOVERY_CYCLES = 500_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hcsr04_gerador_echo.sv
// Echo width generator: cm down-counter plus a CYCLES_PER_CM prescaler,
// or a plain cycle count for out-of-range targets.
module hcsr04_gerador_echo
   import hcsr04_emu_pkg::*;
#(
   parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM,
   parameter int MAX_CM         = DEF_MAX_CM,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DIST_W-1:0] distancia,
   output logic              echo_ativo,
   output logic              fim
);

   localparam int PRE_W = $clog2(max_int(CYCLES_PER_CM, TIMEOUT_CYCLES) + 1);
   localparam logic [PRE_W-1:0]  CPC_LAST = PRE_W'(CYCLES_PER_CM - 1);
   localparam logic [PRE_W-1:0]  TMO_LAST = PRE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DIST_W-1:0] MAX_D    = DIST_W'(MAX_CM);
   localparam logic [DIST_W-1:0] MIN_D    = DIST_W'(2);

   logic [PRE_W-1:0]  r_pre;
   logic [DIST_W-1:0] r_cm;
   logic              r_tmo;
   logic              r_ativo;
   logic              w_ultimo;

   // Last echo cycle: final prescaler tick of the last cm, or end of timeout.
   assign w_ultimo   = r_tmo ? (r_pre >= TMO_LAST)
                             : ((r_cm <= DIST_W'(1)) && (r_pre >= CPC_LAST));
   assign fim        = r_ativo & w_ultimo;
   assign echo_ativo = r_ativo;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pre   <= '0;
         r_cm    <= '0;
         r_tmo   <= 1'b0;
         r_ativo <= 1'b0;
      end else if (start) begin
         r_ativo <= 1'b1;
         r_pre   <= '0;
         r_tmo   <= (distancia > MAX_D);
         r_cm    <= (distancia < MIN_D) ? MIN_D : distancia;
      end else if (r_ativo) begin
         if (w_ultimo) begin
            r_ativo <= 1'b0;
            r_pre   <= '0;
            r_cm    <= '0;
         end else if (!r_tmo && (r_pre >= CPC_LAST)) begin
            r_pre <= '0;
            r_cm  <= r_cm - 1'b1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: trigger synchronizer, protocol FSM and timing counters.
// HCSR04_EMU_DEBUG_EN makes db_estado and trigger_curto live; otherwise both are 0.
module hcsr04_emulador
   import hcsr04_emu_pkg::*;
#(
   parameter int CLK_HZ          = DEF_CLK_HZ,
   parameter int TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
   parameter int BURST_CYCLES    = DEF_BURST_CYCLES,
   parameter int CYCLES_PER_CM   = DEF_CYCLES_PER_CM,
   parameter int MAX_CM          = DEF_MAX_CM,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              trigger,
   input  logic              habilita,
   input  logic [DIST_W-1:0] distancia_cm,
   output logic              echo,
   output logic              ocupado,
   output logic              trigger_curto,
   output logic [3:0]        db_estado
);

   localparam int CNT_MAX = max_int(max_int(TRIG_MIN_CYCLES, BURST_CYCLES),
                                    max_int(RECOVERY_CYCLES,
                                            max_int(TIMEOUT_CYCLES, CLK_HZ / CLK_HZ)));
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TRIG_MIN_C = CNT_W'(TRIG_MIN_CYCLES);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOVERY_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

   logic              r_sync1, r_sync2;
   logic              w_trig_s;
   estado_t           r_estado;
   logic [CNT_W-1:0]  r_cnt;
   logic [DIST_W-1:0] r_dist;
   logic              r_ocupado;
   logic              w_fim_rajada;
   logic              w_echo_ativo;
   logic              w_echo_fim;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= trigger;
         r_sync2 <= r_sync1;
      end
   end
   assign w_trig_s = r_sync2;

   assign w_fim_rajada = (r_estado == RAJADA) && (r_cnt >= BURST_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado  <= REPOUSO;
         r_cnt     <= '0;
         r_dist    <= '0;
         r_ocupado <= 1'b0;
      end else begin
         case (r_estado)
            REPOUSO: begin
               if (w_trig_s && habilita) begin
                  r_estado  <= MEDE_TRIGGER;
                  r_cnt     <= CNT_W'(1);
                  r_ocupado <= 1'b1;
               end
            end
            MEDE_TRIGGER: begin
               if (w_trig_s) begin
                  if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
               end else if (r_cnt >= TRIG_MIN_C) begin
                  r_dist   <= distancia_cm;
                  r_estado <= RAJADA;
                  r_cnt    <= '0;
               end else begin
                  r_estado  <= REPOUSO;
                  r_cnt     <= '0;
                  r_ocupado <= 1'b0;
               end
            end
            RAJADA: begin
               if (w_fim_rajada) begin
                  r_estado <= ECHO_ALTO;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ECHO_ALTO: begin
               if (w_echo_fim) begin
                  r_estado <= RECUPERACAO;
                  r_cnt    <= '0;
               end
            end
            RECUPERACAO: begin
               if (r_cnt >= RECOV_LAST) begin
                  r_estado  <= REPOUSO;
                  r_cnt     <= '0;
                  r_ocupado <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_estado  <= REPOUSO;
               r_cnt     <= '0;
               r_ocupado <= 1'b0;
            end
         endcase
      end
   end

   // Distance is latched at trigger acceptance, so later input changes never reach the pulse in flight.
   hcsr04_gerador_echo #(
      .CYCLES_PER_CM  (CYCLES_PER_CM),
      .MAX_CM         (MAX_CM),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_gerador (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (w_fim_rajada),
      .distancia  (r_dist),
      .echo_ativo (w_echo_ativo),
      .fim        (w_echo_fim)
   );

   assign echo    = w_echo_ativo;
   assign ocupado = r_ocupado;

`ifdef HCSR04_EMU_DEBUG_EN
   logic       r_curto;
   logic [3:0] w_db;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_curto <= 1'b0;
      else          r_curto <= (r_estado == MEDE_TRIGGER) && !w_trig_s && (r_cnt < TRIG_MIN_C);
   end

   always_comb begin
      w_db = DB_ILEGAL;
      case (r_estado)
         REPOUSO, MEDE_TRIGGER, RAJADA, ECHO_ALTO, RECUPERACAO: w_db = {1'b0, r_estado};
         default: w_db = DB_ILEGAL;
      endcase
   end

   assign trigger_curto = r_curto;
   assign db_estado     = w_db;
`else
   assign trigger_curto = 1'b0;
   assign db_estado     = 4'd0;
`endif

endmodule
